sakura_scroll_reader: RTL
=========================

// Module: sakura_scroll_reader
// PURPOSE
// - Downstream consumer of the 8192x16 sakura-tree image BRAM; sits between that BRAM and the 96x64 OLED driver.
// - Maps the OLED pixel_index to a BRAM address, applies a horizontally wrapping scroll offset and colour-key substitution.
// - Drives the BRAM read port and presents RGB565 pixel_data to the OLED with fixed pipeline latency.
// PARAMETERS
// - WIDTH      96       OLED columns (x range 0..WIDTH-1)
// - HEIGHT     64       OLED rows (y range 0..HEIGHT-1)
// - N          13       BRAM / pixel_index address width
// - W          16       pixel width, RGB565
// - FRAME_DIV  4        frame_begin pulses per 1-column scroll step (>=1)
// - KEY_COLOUR 16'hF81F colour treated as transparent in the image
// - BG_COLOUR  16'h0000 colour output for transparent/idle/out-of-range pixels
// PORTS
// - clk          in   1   system clock; all logic on posedge
// - reset        in   1   synchronous, active-high reset
// - pixel_index  in   N   current OLED pixel, y*WIDTH+x
// - frame_begin  in   1   one-cycle pulse at start of each OLED frame
// - run          in   1   1: display image and scroll; 0: hold or idle (see FSM)
// - freeze       in   1   1 while RUN: stop scrolling, keep displaying
// - dir          in   1   scroll direction: 0 offset increments, 1 decrements
// - bram_addr    out  N   registered BRAM address
// - bram_rw      out  1   BRAM read_write; constant 0 (never writes)
// - bram_data    in   W   BRAM data_out, valid 1 cycle after bram_addr
// - pixel_data   out  W   registered pixel to OLED
// - offset       out  7   current scroll offset, 0..WIDTH-1
// BEHAVIOUR
// - Reset: bram_addr=0, bram_rw=0, pixel_data=BG_COLOUR, offset=0, frame counter=0, state=IDLE, pipeline valid bits=0.
// - Address calc, stage 1 (registered): y=pixel_index/WIDTH, x=pixel_index%WIDTH (constant divide; comparator chain allowed).
//   xs=x+offset; if xs>=WIDTH then xs-=WIDTH (single conditional subtract, never modulo of >2*WIDTH).
//   bram_addr=y*WIDTH+xs; in_range=(pixel_index<WIDTH*HEIGHT); out-of-range -> bram_addr=0, in_range=0.
// - Stage 2: BRAM read (1 cycle); block carries in_range and the stage-1 state alongside.
// - Stage 3 (registered): pixel_data = BG_COLOUR if !in_range or state==IDLE or bram_data==KEY_COLOUR, else bram_data.
// - Latency pixel_index -> pixel_data: exactly 3 clk, fully pipelined, one pixel per cycle, no stalls.
// - FSM states: IDLE, RUN, HOLD.
//   IDLE: output BG_COLOUR; offset held. run=1 -> RUN.
//   RUN: on frame_begin, frame counter++; when counter reaches FRAME_DIV-1 on a frame_begin, counter->0 and offset steps.
//        freeze=1 -> HOLD; run=0 -> IDLE.
//   HOLD: image shown, offset and counter frozen. freeze=0 -> RUN; run=0 -> IDLE (run=0 has priority over freeze).
// - Offset step: dir=0: 95->0 wrap; dir=1: 0->95 wrap. Offset updates only on frame_begin, so one frame never shows two offsets.
// - frame_begin coinciding with a state change: transition taken, no step in that cycle.
// - Leaving RUN (to IDLE or HOLD) keeps offset; re-entering IDLE does not clear offset; only reset clears it.
// - reset mid-frame: all stages flushed; next 3 cycles output BG_COLOUR regardless of bram_data.
// - bram_rw tied 0 in all states including reset.
// STRUCTURE
// - Shared package/header: WIDTH, HEIGHT, N, W, RGB565 colour constants (KEY_COLOUR, BG_COLOUR), FSM state encodings.
// - One sub-module: pixel_xy_split (pixel_index -> x,y, combinational, reused by other OLED consumers).
// - Top holds FSM, offset/frame counters, 3-stage pipeline.
// TESTING
// - Reset then run=0, sweep pixel_index 0..6143 -> pixel_data==BG_COLOUR always, bram_rw==0, offset==0.
// - run=1, offset=0, pixel_index=97 -> bram_addr=97 after 1 clk, pixel_data==bram_data after 3 clk (model BRAM with addr pattern).
// - Force offset to 95 via 95 steps (FRAME_DIV=1), pixel_index=96+5 -> bram_addr=96+4 (wrap), offset after one more frame_begin ==0.
// - dir=1 from offset 0, one step -> offset==95; FRAME_DIV=4: 3 frame_begin pulses -> no change, 4th -> step.
// - bram_data=16'hF81F at in-range pixel -> pixel_data==BG_COLOUR; pixel_index=6144 -> bram_addr=0, pixel_data==BG_COLOUR.
// - freeze=1 for 8 frames -> offset unchanged; run=0 with freeze=1 -> IDLE; reset mid-stream -> BG_COLOUR for 3 clk, offset=0.

Source files
------------

// File: rtl/sakura_scroll_reader_pkg.sv
// Shared constants and types for the sakura image reader.
// OLED geometry, RGB565 colour keys and FSM encodings.
package sakura_scroll_reader_pkg;

  localparam int WIDTH  = 96;
  localparam int HEIGHT = 64;
  localparam int N      = 13;
  localparam int W      = 16;
  localparam int OW     = 7;
  localparam int XW     = 7;

  localparam logic [W-1:0] KEY_COLOUR = 16'hF81F;
  localparam logic [W-1:0] BG_COLOUR  = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/pixel_xy_split.sv
// Splits an OLED pixel_index into column x and row y.
// Pure combinational; divisor is a constant.
module pixel_xy_split
  import sakura_scroll_reader_pkg::*;
(
  input  logic [N-1:0]  pixel_index_i,
  output logic [XW-1:0] x_o,
  output logic [N-1:0]  y_o
);

  assign y_o = pixel_index_i / N'(WIDTH);
  assign x_o = XW'(pixel_index_i % N'(WIDTH));

endmodule

// File: rtl/sakura_scroll_reader.sv
// Scrolling BRAM image reader feeding the 96x64 OLED.
// Three-stage pipeline: address, BRAM read, colour key.
module sakura_scroll_reader
  import sakura_scroll_reader_pkg::*;
#(
  parameter int unsigned FRAME_DIV = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  pixel_index,
  input  logic          frame_begin,
  input  logic          run,
  input  logic          freeze,
  input  logic          dir,
  output logic [N-1:0]  bram_addr,
  output logic          bram_rw,
  input  logic [W-1:0]  bram_data,
  output logic [W-1:0]  pixel_data,
  output logic [OW-1:0] offset
);

  localparam int CW =
    (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);
  localparam logic [OW-1:0] OFF_LAST = OW'(WIDTH - 1);
  localparam logic [N-1:0]  PIX_LIM  = N'(WIDTH * HEIGHT);
  localparam logic [N-1:0]  WN       = N'(WIDTH);
  localparam logic [XW:0]   XLIM     = (XW+1)'(WIDTH);

  state_e        state_q, state_d;
  logic [OW-1:0] offset_q, offset_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // run=0 wins over freeze in both RUN and HOLD
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (run) state_d = ST_RUN;
      ST_RUN: begin
        if (!run)       state_d = ST_IDLE;
        else if (freeze) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!run)        state_d = ST_IDLE;
        else if (!freeze) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    step = (state_q == ST_RUN) && (state_d == ST_RUN)
           && frame_begin;
    cnt_d    = cnt_q;
    offset_d = offset_q;
    if (step) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (dir)
          offset_d = (offset_q == '0) ? OFF_LAST
                                      : offset_q - OW'(1);
        else
          offset_d = (offset_q == OFF_LAST) ? '0
                                            : offset_q + OW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      offset_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
    end
  end

  logic [XW-1:0] x, xs;
  logic [N-1:0]  y, addr_d;
  logic [XW:0]   xsum;
  logic          in_range;

  pixel_xy_split u_split (
    .pixel_index_i (pixel_index),
    .x_o           (x),
    .y_o           (y)
  );

  always_comb begin
    in_range = pixel_index < PIX_LIM;
    xsum     = {1'b0, x} + {1'b0, offset_q};
    if (xsum >= XLIM) xsum = xsum - XLIM;
    xs     = xsum[XW-1:0];
    addr_d = in_range ? (y * WN) + {{(N-XW){1'b0}}, xs}
                      : '0;
  end

  logic [N-1:0] addr_q;
  logic [W-1:0] pix_q;
  logic         v1_q, v2_q;

  // v carries in_range gated by the non-IDLE state of stage 1
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      pix_q  <= BG_COLOUR;
    end else begin
      addr_q <= addr_d;
      v1_q   <= in_range && (state_q != ST_IDLE);
      v2_q   <= v1_q;
      pix_q  <= (v2_q && bram_data != KEY_COLOUR)
                ? bram_data : BG_COLOUR;
    end
  end

  assign bram_addr  = addr_q;
  assign bram_rw    = 1'b0;
  assign pixel_data = pix_q;
  assign offset     = offset_q;

endmodule
